// File: rtl/xbar_output_buffer.sv
// ----------------------------------------------------------------------------
// xbar_output_buffer
//
// Purpose:
//   Per-output-port FIFO between the switch crossbar and the outgoing link of a
//   mesh router. The crossbar control unit writes flits with wr_en_i/data_i and
//   watches full_o. The link side is a show-ahead valid/ready interface that
//   always presents the oldest stored flit on data_o.
//
// Parameters:
//   DATA_W  flit width in bits
//   DEPTH   number of FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_ni    synchronous active-low reset (pointers and occupancy only)
//   wr_en_i   write strobe from the crossbar control unit
//   data_i    flit from the crossbar mux
//   full_o    FIFO holds DEPTH entries
//   data_o    head flit toward the link (don't-care while vld_o = 0)
//   vld_o     data_o holds a valid flit
//   rdy_i     link consumer accepts data_o this cycle
//   count_o   current occupancy, 0..DEPTH
//   ovf_o     sticky overflow flag (only with OUT_BUF_OVF_EN)
//
// Configuration:
//   OUT_BUF_OVF_EN  when defined, adds ovf_o, which sets on the cycle after a
//                   write is rejected because the FIFO is full and holds until
//                   reset. When undefined, rejected writes vanish silently.
// ----------------------------------------------------------------------------
module xbar_output_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     full_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     vld_o,
    input  logic                     rdy_i,
`ifdef OUT_BUF_OVF_EN
    output logic                     ovf_o,
`endif
    output logic [$clog2(DEPTH):0]   count_o
);

    // Storage index width and pointer width. The extra pointer bit lets the
    // pointers run modulo 2*DEPTH, so their difference equals occupancy.
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [PtrW-1:0] DepthVal = PtrW'(DEPTH);
    localparam logic [PtrW-1:0] Zero     = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   count_q,  count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IdxW-1:0]   wr_idx;
    logic [IdxW-1:0]   rd_idx;

    logic              full;
    logic              not_empty;
    logic              wr_accept;
    logic              wr_reject;
    logic              rd_fire;

    // ------------------------------------------------------------------------
    // Status decode, purely from registered state so that no output has a
    // combinational path from wr_en_i or rdy_i.
    // ------------------------------------------------------------------------
    assign full      = (count_q == DepthVal);
    assign not_empty = (count_q != Zero);

    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];

    // ------------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------------
    // A write while full is dropped even if the head leaves in the same cycle;
    // the freed slot only becomes writable on the next cycle.
    assign wr_accept = wr_en_i && !full;
    assign wr_reject = wr_en_i && full;

    // An idle consumer asserting rdy_i against an empty FIFO does nothing.
    assign rd_fire   = not_empty && rdy_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end

        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case ({wr_accept, rd_fire})
            2'b10:   count_d = count_q + PtrOne;
            2'b01:   count_d = count_q - PtrOne;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers, synchronous reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= Zero;
            rd_ptr_q <= Zero;
            count_q  <= Zero;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Flit storage. Not reset: an entry is only observable after it has been
    // written, because vld_o gates the head.
    // A write during reset must not be able to disturb anything visible, and
    // since the pointers are being cleared it cannot, so no reset gating here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    // ------------------------------------------------------------------------
    // Optional sticky overflow flag
    // ------------------------------------------------------------------------
`ifdef OUT_BUF_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_reject) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    // Rejects cannot occur with a well-behaved control unit; the strobe is
    // left unobserved in this build.
    logic unused_wr_reject;
    assign unused_wr_reject = wr_reject;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign full_o  = full;
    assign vld_o   = not_empty;
    assign data_o  = mem_q[rd_idx];   // show-ahead head flit
    assign count_o = count_q;

    // ------------------------------------------------------------------------
    // Internal consistency checks
    // ------------------------------------------------------------------------
    // Occupancy never exceeds the storage size.
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthVal);

    // Occupancy always matches the pointer distance modulo 2*DEPTH.
    a_count_ptr : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q == PtrW'(wr_ptr_q - rd_ptr_q));

    // A stalled head stays put until the consumer takes it.
    a_hold_head : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (not_empty && !rdy_i) |=> (rd_ptr_q == $past(rd_ptr_q)));

endmodule

// File: tb/tb_xbar_output_buffer.sv
// Bench for xbar_output_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the FIFO.
module tb_xbar_output_buffer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              wr_en_i;
    logic [DATA_W-1:0] data_i;
    logic              full_o;
    logic [DATA_W-1:0] data_o;
    logic              vld_o;
    logic              rdy_i;
    logic [$clog2(DEPTH):0] count_o;
`ifdef OUT_BUF_OVF_EN
    logic              ovf_o;
`endif

    xbar_output_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_en_i (wr_en_i),
        .data_i  (data_i),
        .full_o  (full_o),
        .data_o  (data_o),
        .vld_o   (vld_o),
        .rdy_i   (rdy_i),
`ifdef OUT_BUF_OVF_EN
        .ovf_o   (ovf_o),
`endif
        .count_o (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: the FIFO contents as a queue, oldest first.
    logic [DATA_W-1:0] model_q[$];
    bit                model_ovf;
    int unsigned       n_writes;
    int unsigned       n_reads;

    int unsigned n_checks;
    int unsigned n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle with the given inputs; the model advances on the same edge.
    task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rdy);
        bit acc;
        bit rej;
        bit rd;
        wr_en_i = wr;
        data_i  = d;
        rdy_i   = rdy;
        @(posedge clk_i);
        if (!rst_ni) begin
            model_q.delete();
            model_ovf = 1'b0;
            n_writes  = 0;
            n_reads   = 0;
        end else begin
            acc = wr && (model_q.size() < DEPTH);
            rej = wr && (model_q.size() == DEPTH);
            rd  = (model_q.size() > 0) && rdy;
            if (rd) begin
                void'(model_q.pop_front());
                n_reads++;
            end
            if (acc) begin
                model_q.push_back(d);
                n_writes++;
            end
            if (rej) model_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count_o), 32'(model_q.size()));
        check({tag, ".vld"},   32'(vld_o),   32'(model_q.size() != 0));
        check({tag, ".full"},  32'(full_o),  32'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            check({tag, ".data"}, 32'(data_o), 32'(model_q[0]));
        end
`ifdef OUT_BUF_OVF_EN
        check({tag, ".ovf"}, 32'(ovf_o), 32'(model_ovf));
`endif
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        rst_ni = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_ovf = 1'b0;
        n_writes  = 0;
        n_reads   = 0;
        rst_ni    = 1'b0;
        wr_en_i   = 1'b0;
        data_i    = '0;
        rdy_i     = 1'b0;

        // T1: reset while writing
        do_reset();
        check("t1_count", 32'(count_o), 32'd0);
        check("t1_vld",   32'(vld_o),   32'd0);
        check("t1_full",  32'(full_o),  32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("t1_post_vld", 32'(vld_o), 32'd0);
        check_state("t1");

        // T2: fill, reject, drain
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        check("t2_full",  32'(full_o),  32'd1);
        check("t2_count", 32'(count_o), 32'd4);
        step(1'b1, 8'h05, 1'b0);
        check("t2_rej_count", 32'(count_o), 32'd4);
        check("t2_rej_head",  32'(data_o),  32'h01);
        check_state("t2_rej");
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain", 32'(data_o), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("t2_empty", 32'(vld_o), 32'd0);
        check_state("t2_end");

        // T3: backpressure
        do_reset();
        step(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            check("t3_hold_data", 32'(data_o), 32'h5A);
            check("t3_hold_vld",  32'(vld_o),  32'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        check("t3_consumed", 32'(vld_o), 32'd0);

        // T4: streaming, one cycle behind the input
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b1);
            check("t4_data",  32'(data_o),  32'(i));
            check("t4_count", 32'(count_o), 32'd1);
            check("t4_full",  32'(full_o),  32'd0);
        end
        step(1'b0, 8'h00, 1'b1);
        check_state("t4_end");

        // T5: random mixed traffic, pointers wrap several times
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            check_state("t5");
            check("t5_wr_minus_rd", 32'(count_o), n_writes - n_reads);
        end

        // T6: full with simultaneous write and read
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        check("t6_full", 32'(full_o), 32'd1);
        step(1'b1, 8'hEE, 1'b1);
        check("t6_count", 32'(count_o), 32'd3);
        check("t6_head",  32'(data_o),  32'h11);
        check_state("t6");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check_state("t6_drain");
        end
        check("t6_empty", 32'(vld_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
